data_memory_sync: RTL and testbench

- Parametrised successor to the 8-word combinational-read data memory in the RISC datapath.
- Generic width and depth; registered read with a valid/ready request handshake.
- Hardware clear sweep after reset, with out-of-range address detection.
- Sits between the datapath memory stage and the memory array; the core stalls on req_ready=0.

---
 rtl/data_memory_sync_if.sv | 23 ++
 rtl/data_memory_sync.sv | 61 ++++++
 tb/tb_data_memory_sync.sv | 139 +++++++++++++
 3 files changed

// File: rtl/data_memory_sync_if.sv
// data_memory_sync_if: request/response bundle between the core memory stage and data_memory_sync
interface data_memory_sync_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_err;
  logic              busy;
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rd_valid, rd_data, rd_err, busy
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rd_valid, rd_data, rd_err, busy
  );
endinterface

// File: rtl/data_memory_sync.sv
// data_memory_sync: parametrised data memory, registered read, valid/ready requests, zeroing sweep after reset
module data_memory_sync #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 8
) (
  input logic              clk,
  input logic              rst,
  data_memory_sync_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  // Range compare is done wide enough that DEPTH itself is representable.
  localparam int CW = ADDR_W + 18;
  typedef enum logic {S_CLEAR, S_READY} state_t;
  state_t            r_state, w_next;
  logic [IDX_W-1:0]  r_clr_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_rd_valid, r_rd_err;
  logic [DATA_W-1:0] r_rd_data;
  logic              w_ready, w_busy, w_accept, w_in_range;
  logic [IDX_W-1:0]  w_idx;
  always_comb begin
    w_ready = r_state == S_READY;
    w_busy  = r_state == S_CLEAR;
    w_next  = (w_busy && r_clr_cnt == IDX_W'(DEPTH - 1)) ? S_READY : r_state;
  end
  assign w_accept   = bus.req_valid && w_ready;
  assign w_in_range = CW'(bus.req_addr) < CW'(DEPTH);
  assign w_idx      = bus.req_addr[IDX_W-1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_busy) r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_busy) r_mem[r_clr_cnt] <= '0;
      else if (w_accept && bus.req_we && w_in_range) r_mem[w_idx] <= bus.req_wdata;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_accept && !bus.req_we;
      r_rd_err   <= w_accept && !w_in_range;
      if (w_accept && !bus.req_we) r_rd_data <= w_in_range ? r_mem[w_idx] : '0;
    end
  end
  assign bus.req_ready = w_ready;
  assign bus.busy      = w_busy;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_err    = r_rd_err;
  assign bus.rd_data   = r_rd_data;
endmodule

// File: tb/tb_data_memory_sync.sv
// tb_data_memory_sync: directed table, corner sequences and random traffic against a word-array model
module tb_data_memory_sync;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  data_memory_sync_if #(.DATA_W(16), .ADDR_W(16)) bus ();
  data_memory_sync #(.DATA_W(16), .ADDR_W(16), .DEPTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  int nvec = 0;
  int nmis = 0;
  logic [15:0] m_mem [8];
  int          m_left;
  logic        e_v, e_e;
  logic [15:0] e_d;
  typedef struct {
    logic        v, we;
    logic [15:0] a, wd;
    logic        xv, xe;
    logic [15:0] xd;
  } vec_t;
  vec_t tbl [12];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  // One clock: drive, check ready/busy before the edge, advance model, check response after.
  task automatic step(input logic r, input logic v, input logic we, input logic [15:0] a, input logic [15:0] wd);
    logic acc;
    rst = r;
    bus.req_valid = v;
    bus.req_we = we;
    bus.req_addr = a;
    bus.req_wdata = wd;
    #1;
    chk("req_ready", {31'b0, bus.req_ready}, {31'b0, m_left == 0});
    chk("busy", {31'b0, bus.busy}, {31'b0, m_left != 0});
    acc = !r && v && m_left == 0;
    @(posedge clk);
    if (r) begin
      m_left = 8;
      foreach (m_mem[i]) m_mem[i] = '0;
      e_v = 0;
      e_e = 0;
      e_d = 0;
    end else begin
      if (m_left > 0) m_left--;
      e_v = acc && !we;
      e_e = acc && a >= 16'd8;
      if (acc && we && a < 16'd8) m_mem[a[2:0]] = wd;
      else if (e_v) e_d = a < 16'd8 ? m_mem[a[2:0]] : 16'h0;
    end
    #1;
    chk("rd_valid", {31'b0, bus.rd_valid}, {31'b0, e_v});
    chk("rd_err", {31'b0, bus.rd_err}, {31'b0, e_e});
    chk("rd_data", {16'b0, bus.rd_data}, {16'b0, e_d});
  endtask
  task automatic idle();
    step(0, 0, 0, 16'h0, 16'h0);
  endtask
  initial begin
    int cnt;
    tbl[0]  = '{1, 1, 16'd0,    16'h0006, 0, 0, 16'h0000};
    tbl[1]  = '{1, 1, 16'd7,    16'h0005, 0, 0, 16'h0000};
    tbl[2]  = '{1, 0, 16'd0,    16'h0000, 1, 0, 16'h0006};
    tbl[3]  = '{1, 0, 16'd7,    16'h0000, 1, 0, 16'h0005};
    tbl[4]  = '{1, 1, 16'd8,    16'hBEEF, 0, 1, 16'h0005};
    tbl[5]  = '{1, 0, 16'h0010, 16'h0000, 1, 1, 16'h0000};
    tbl[6]  = '{1, 0, 16'd0,    16'h0000, 1, 0, 16'h0006};
    tbl[7]  = '{0, 0, 16'd0,    16'h0000, 0, 0, 16'h0006};
    tbl[8]  = '{1, 1, 16'd2,    16'h1234, 0, 0, 16'h0006};
    tbl[9]  = '{1, 0, 16'd2,    16'h0000, 1, 0, 16'h1234};
    tbl[10] = '{0, 0, 16'd0,    16'h0000, 0, 0, 16'h1234};
    tbl[11] = '{1, 0, 16'hFFFF, 16'h0000, 1, 1, 16'h0000};
    rst = 1;
    bus.req_valid = 0;
    bus.req_we = 0;
    bus.req_addr = 0;
    bus.req_wdata = 0;
    @(posedge clk);
    m_left = 8;
    foreach (m_mem[i]) m_mem[i] = '0;
    e_v = 0;
    e_e = 0;
    e_d = 0;
    #1;
    chk("reset rd_valid", {31'b0, bus.rd_valid}, 32'd0);
    chk("reset rd_data", {16'b0, bus.rd_data}, 32'd0);
    // Sweep length and zeroed contents
    step(1, 0, 0, 16'h0, 16'h0);
    cnt = 0;
    while (bus.busy && cnt < 20) begin
      idle();
      cnt++;
    end
    chk("sweep cycles", cnt, 32'd8);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 16'(i), 16'h0);
    idle();
    // Directed table
    for (int i = 0; i < 12; i++) begin
      step(0, tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].wd);
      chk("tbl rd_valid", {31'b0, bus.rd_valid}, {31'b0, tbl[i].xv});
      chk("tbl rd_err", {31'b0, bus.rd_err}, {31'b0, tbl[i].xe});
      chk("tbl rd_data", {16'b0, bus.rd_data}, {16'b0, tbl[i].xd});
    end
    // Request held through reset and the sweep
    step(1, 1, 0, 16'd3, 16'h0);
    cnt = 0;
    while (!bus.rd_valid && cnt < 20) begin
      step(0, 1, 0, 16'd3, 16'h0);
      cnt++;
    end
    chk("held read latency", cnt, 32'd9);
    chk("held read data", {16'b0, bus.rd_data}, 32'd0);
    idle();
    // Reset mid-sweep restarts the sweep
    step(0, 1, 1, 16'd5, 16'hAAAA);
    step(1, 0, 0, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) idle();
    step(1, 0, 0, 16'h0, 16'h0);
    cnt = 0;
    while (bus.busy && cnt < 20) begin
      idle();
      cnt++;
    end
    chk("restart sweep cycles", cnt, 32'd8);
    step(0, 1, 0, 16'd5, 16'h0);
    chk("cleared @5", {16'b0, bus.rd_data}, 32'd0);
    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 9));
      step($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, 16'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
